header_egress_arbiter: RTL and testbench
========================================

HEADER_EGRESS_ARBITER -- requirements
Module: header_egress_arbiter

Interface
REQ-001 SHALL have parameter NUM_LINKS, default 4, the number of header-sorter requesters (2..8).
REQ-002 SHALL have parameter HDR_WIDTH, default 96, the sorted-header width.
REQ-003 SHALL have parameter PLD_WIDTH, default 32, the payload-beat width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-006 SHALL have port req_valid, input, NUM_LINKS bits: per-link request valid.
REQ-007 SHALL have port req_header, input, NUM_LINKS*HDR_WIDTH bits: per-link sorted header, with link i at slice [i*HDR_WIDTH +: HDR_WIDTH].
REQ-008 SHALL have port req_payload, input, NUM_LINKS*PLD_WIDTH bits: per-link payload beat.
REQ-009 SHALL have port req_dest, input, NUM_LINKS*3 bits: per-link subunit code (1 = config, 2 = memory, 3 = I/O).
REQ-010 SHALL have port req_has_pld, input, NUM_LINKS bits: set when the request carries one payload beat.
REQ-011 SHALL have port req_ready, output, NUM_LINKS bits: a one-hot accept to the link that wins arbitration.
REQ-012 SHALL have port out_valid, input side of the downstream handshake, output, 1 bit: beat valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream subunit accepts the beat.
REQ-014 SHALL have ports out_header (output, HDR_WIDTH bits), out_payload (output, PLD_WIDTH bits), out_dest (output, 3 bits) and out_link (output, 3 bits): the beat contents.
REQ-015 SHALL have port out_is_pld, output, 1 bit: 0 for the header beat, 1 for the payload beat.
REQ-016 SHALL have ports drop_count (output, 8 bits) and busy (output, 1 bit).

Function
REQ-017 SHALL implement a state machine with the states IDLE, HDR and PLD.
REQ-018 In IDLE, SHALL drive req_ready as the combinational one-hot round-robin winner among the asserted req_valid bits, starting the search at rr_ptr; all req_ready bits SHALL be 0 in HDR and PLD.
REQ-019 On an accept (req_valid[i] & req_ready[i]), SHALL register link i's header, payload, dest and has_pld, and set rr_ptr = (i+1) mod NUM_LINKS.
REQ-020 After an accept with a valid dest (1..3), SHALL enter HDR on the next cycle; accept-to-out_valid latency SHALL be 1 cycle.
REQ-021 After an accept with an invalid dest (0 or 4..7), SHALL discard the request, stay in IDLE, and increment drop_count, saturating at 255; rr_ptr SHALL still advance.
REQ-022 In HDR, SHALL hold out_valid=1, out_is_pld=0, the registered header/dest/link, and out_payload=0 stable until out_ready.
REQ-023 On out_ready in HDR, SHALL go to PLD if has_pld, else to IDLE.
REQ-024 In PLD, SHALL hold out_valid=1, out_is_pld=1, the registered payload, and header/dest/link unchanged until out_ready; on out_ready it SHALL go to IDLE.
REQ-025 SHALL allow no new accept in the cycle a beat completes: the minimum is 3 cycles per header-only request and 4 per request with payload.
REQ-026 SHALL drive busy=1 in HDR and PLD.
REQ-027 SHALL tolerate req_valid being withdrawn while not granted, with no side effects.
REQ-028 With a single requester continuously valid, SHALL serve it back-to-back with no starvation of others once they assert.

Reset
REQ-029 When rst_n=0 at a clock edge, SHALL set state=IDLE, rr_ptr=0, drop_count=0, and all registered beat fields to 0.
REQ-030 While rst_n=0, SHALL drive out_valid=0, req_ready=0, busy=0, out_is_pld=0, and out_header/out_payload/out_dest/out_link=0.
REQ-031 On reset asserted mid-transfer (HDR or PLD), SHALL abandon the transfer with no further beats of it emitted after release.

Structure
REQ-032 SHALL take its constants from the shared package hdr_pkg: the dest codes DEST_CFG=1, DEST_MEM=2, DEST_IO=3; the state enum; and the HDR_WIDTH/PLD_WIDTH defaults.
REQ-033 SHALL place the round-robin search in one sub-module, rr_arbiter (inputs: request vector and pointer; output: one-hot grant); the rest SHALL be flat.

Verification
REQ-034 Single request: link 2 with dest=2, has_pld=1, header=96'hA5, payload=32'hDEAD, and out_ready=1 -> the header beat appears 1 cycle after the accept (out_link=2), the payload beat 32'hDEAD on the next cycle, then IDLE.
REQ-035 All 4 links valid from reset, header-only, out_ready=1 -> grant order 0,1,2,3,0, with each accept 3 cycles apart.
REQ-036 Backpressure: out_ready=0 for 5 cycles during HDR -> out_valid and out_header stable for all 5 cycles, with no req_ready asserted.
REQ-037 Invalid dest: dest=0 on link 1 repeated 300 times -> no out_valid, and drop_count saturates at 255.
REQ-038 Reset in PLD: rst_n=0 for 1 cycle -> out_valid=0, rr_ptr=0, and the next grant goes to the lowest valid link.

Source files
------------

// File: rtl/hdr_pkg.sv
// Shared constants for the header egress path: subunit dest codes,
// arbiter FSM states and default beat widths.
package hdr_pkg;

  localparam logic [2:0] DEST_CFG = 3'd1;
  localparam logic [2:0] DEST_MEM = 3'd2;
  localparam logic [2:0] DEST_IO  = 3'd3;

  localparam int HDR_WIDTH_DEF = 96;
  localparam int PLD_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PLD  = 2'd2
  } state_e;

  function automatic logic dest_is_valid(input logic [2:0] dest);
    return (dest == DEST_CFG) || (dest == DEST_MEM) || (dest == DEST_IO);
  endfunction

endpackage

// File: rtl/header_egress_arbiter_if.sv
// Request side (per-link sorted headers) and downstream beat handshake of the
// header egress arbiter; master is the arbiter, slave is its environment.
interface header_egress_arbiter_if
  import hdr_pkg::*;
#(
  parameter int NUM_LINKS = 4,
  parameter int HDR_WIDTH = HDR_WIDTH_DEF,
  parameter int PLD_WIDTH = PLD_WIDTH_DEF
);

  logic [NUM_LINKS-1:0]           req_valid;
  logic [NUM_LINKS*HDR_WIDTH-1:0] req_header;
  logic [NUM_LINKS*PLD_WIDTH-1:0] req_payload;
  logic [NUM_LINKS*3-1:0]         req_dest;
  logic [NUM_LINKS-1:0]           req_has_pld;
  logic [NUM_LINKS-1:0]           req_ready;

  logic                           out_valid;
  logic                           out_ready;
  logic [HDR_WIDTH-1:0]           out_header;
  logic [PLD_WIDTH-1:0]           out_payload;
  logic [2:0]                     out_dest;
  logic [2:0]                     out_link;
  logic                           out_is_pld;

  modport master (
    input  req_valid, req_header, req_payload, req_dest, req_has_pld,
    output req_ready,
    output out_valid, out_header, out_payload, out_dest, out_link, out_is_pld,
    input  out_ready
  );

  modport slave (
    output req_valid, req_header, req_payload, req_dest, req_has_pld,
    input  req_ready,
    input  out_valid, out_header, out_payload, out_dest, out_link, out_is_pld,
    output out_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot round-robin search: the lowest request at or above ptr wins,
// otherwise the search wraps to the lowest request overall.
module rr_arbiter #(
  parameter int NUM_LINKS = 4
) (
  input  logic [NUM_LINKS-1:0] req,
  input  logic [2:0]           ptr,
  output logic [NUM_LINKS-1:0] grant
);

  localparam logic [NUM_LINKS-1:0] LSB_ONE = {{(NUM_LINKS-1){1'b0}}, 1'b1};

  logic [NUM_LINKS-1:0] upper_s;
  logic [NUM_LINKS-1:0] upper_first_s;
  logic [NUM_LINKS-1:0] any_first_s;

  // x & -x isolates the lowest set bit of each candidate vector.
  always_comb begin
    grant         = {NUM_LINKS{1'b0}};
    upper_s       = req & ({NUM_LINKS{1'b1}} << ptr);
    upper_first_s = upper_s & (~upper_s + LSB_ONE);
    any_first_s   = req & (~req + LSB_ONE);
    if (upper_s != {NUM_LINKS{1'b0}}) begin
      grant = upper_first_s;
    end else begin
      grant = any_first_s;
    end
  end

endmodule

// File: rtl/header_egress_arbiter.sv
// Round-robin egress arbiter: grants one header-sorter link at a time and
// forwards its header beat, then its optional payload beat, downstream.
module header_egress_arbiter
  import hdr_pkg::*;
#(
  parameter int NUM_LINKS = 4,
  parameter int HDR_WIDTH = HDR_WIDTH_DEF,
  parameter int PLD_WIDTH = PLD_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  header_egress_arbiter_if.master bus,
  output logic [7:0]              drop_count,
  output logic                    busy
);

  state_e               state_r;
  state_e               next_state_s;
  logic [2:0]           rr_ptr_r;
  logic [2:0]           next_ptr_s;
  logic [2:0]           grant_idx_s;
  logic [NUM_LINKS-1:0] grant_s;
  logic                 accept_s;
  logic                 finish_s;
  logic                 active_s;
  logic                 cooldown_r;
  logic [HDR_WIDTH-1:0] hdr_sel_s;
  logic [HDR_WIDTH-1:0] hdr_r;
  logic [PLD_WIDTH-1:0] pld_sel_s;
  logic [PLD_WIDTH-1:0] pld_r;
  logic [2:0]           dest_sel_s;
  logic [2:0]           dest_r;
  logic [2:0]           link_r;
  logic                 has_pld_sel_s;
  logic                 has_pld_r;
  logic [7:0]           drop_count_r;

  rr_arbiter #(.NUM_LINKS(NUM_LINKS)) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  // Mux the winning link's fields; grant_s is one-hot or all-zero.
  always_comb begin
    grant_idx_s   = 3'd0;
    hdr_sel_s     = {HDR_WIDTH{1'b0}};
    pld_sel_s     = {PLD_WIDTH{1'b0}};
    dest_sel_s    = 3'd0;
    has_pld_sel_s = 1'b0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      grant_idx_s   = grant_idx_s | (grant_s[i] ? 3'(i) : 3'd0);
      hdr_sel_s     = hdr_sel_s | (grant_s[i] ? bus.req_header[i*HDR_WIDTH +: HDR_WIDTH]
                                              : {HDR_WIDTH{1'b0}});
      pld_sel_s     = pld_sel_s | (grant_s[i] ? bus.req_payload[i*PLD_WIDTH +: PLD_WIDTH]
                                              : {PLD_WIDTH{1'b0}});
      dest_sel_s    = dest_sel_s | (grant_s[i] ? bus.req_dest[i*3 +: 3] : 3'd0);
      has_pld_sel_s = has_pld_sel_s | (grant_s[i] & bus.req_has_pld[i]);
    end
    next_ptr_s = (grant_idx_s == 3'(NUM_LINKS - 1)) ? 3'd0 : grant_idx_s + 3'd1;
  end

  // Next-state logic; cooldown_r blocks an accept right after a transfer ends.
  always_comb begin
    next_state_s = state_r;
    finish_s     = 1'b0;
    accept_s     = rst_n && (state_r == IDLE) && !cooldown_r &&
                   (grant_s != {NUM_LINKS{1'b0}});
    case (state_r)
      IDLE: begin
        if (accept_s && dest_is_valid(dest_sel_s)) begin
          next_state_s = HDR;
        end else begin
          next_state_s = IDLE;
        end
      end
      HDR: begin
        if (bus.out_ready) begin
          finish_s     = !has_pld_r;
          next_state_s = has_pld_r ? PLD : IDLE;
        end else begin
          next_state_s = HDR;
        end
      end
      PLD: begin
        if (bus.out_ready) begin
          finish_s     = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = PLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Beat outputs are forced quiet while rst_n is low, even before the reset edge.
  always_comb begin
    active_s        = rst_n && (state_r != IDLE);
    bus.req_ready   = accept_s ? grant_s : {NUM_LINKS{1'b0}};
    bus.out_valid   = active_s;
    bus.out_is_pld  = active_s && (state_r == PLD);
    bus.out_header  = active_s ? hdr_r : {HDR_WIDTH{1'b0}};
    bus.out_payload = (active_s && (state_r == PLD)) ? pld_r : {PLD_WIDTH{1'b0}};
    bus.out_dest    = active_s ? dest_r : 3'd0;
    bus.out_link    = active_s ? link_r : 3'd0;
    busy            = active_s;
    drop_count      = drop_count_r;
  end

  // State, pointer and captured request fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= 3'd0;
      cooldown_r   <= 1'b0;
      hdr_r        <= {HDR_WIDTH{1'b0}};
      pld_r        <= {PLD_WIDTH{1'b0}};
      dest_r       <= 3'd0;
      link_r       <= 3'd0;
      has_pld_r    <= 1'b0;
      drop_count_r <= 8'd0;
    end else begin
      state_r    <= next_state_s;
      cooldown_r <= finish_s;
      if (accept_s) begin
        rr_ptr_r  <= next_ptr_s;
        hdr_r     <= hdr_sel_s;
        pld_r     <= pld_sel_s;
        dest_r    <= dest_sel_s;
        link_r    <= grant_idx_s;
        has_pld_r <= has_pld_sel_s;
        if (!dest_is_valid(dest_sel_s) && (drop_count_r != 8'd255)) begin
          drop_count_r <= drop_count_r + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_header_egress_arbiter.sv
// Directed self-checking bench for header_egress_arbiter (4 links, 96/32-bit beats).
module tb_header_egress_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] drop_count;
  logic       busy;
  int         n_checks = 0;
  int         n_fail = 0;

  header_egress_arbiter_if #(.NUM_LINKS(4), .HDR_WIDTH(96), .PLD_WIDTH(32)) bus ();

  header_egress_arbiter #(.NUM_LINKS(4), .HDR_WIDTH(96), .PLD_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_link(input int i, input logic [95:0] h, input logic [31:0] p,
                          input logic [2:0] d, input logic hp);
    bus.req_header[i*96 +: 96] = h;
    bus.req_payload[i*32 +: 32] = p;
    bus.req_dest[i*3 +: 3] = d;
    bus.req_has_pld[i] = hp;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_link(i, 96'h1000 + 96'(i), 32'h0, 3'd1, 1'b0);
    tick();
    tick();
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_busy got=%b%b exp=00", bus.out_valid, busy);
    end
    n_checks++;
    if (drop_count !== 8'd0 || bus.out_header !== 96'h0 || bus.out_link !== 3'd0) begin
      n_fail++; $display("FAIL reset_fields drop=%0d hdr=%h link=%0d exp=0", drop_count,
                         bus.out_header, bus.out_link);
    end
  endtask

  // All links valid straight out of reset, header-only: grants 0,1,2,3,0 every 3 cycles.
  task automatic test_rr_order();
    logic [3:0] exp_rdy;
    int         lnk;
    rst_n = 1'b1;
    #1;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      lnk = (cyc / 3) % 4;
      exp_rdy = (cyc % 3 == 0) ? (4'b0001 << lnk) : 4'b0000;
      n_checks++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
      end
      if (cyc % 3 == 1) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_link !== 3'(lnk) ||
            bus.out_header !== 96'h1000 + 96'(lnk) || bus.out_dest !== 3'd1) begin
          n_fail++; $display("FAIL rr_beat cyc=%0d valid=%b link=%0d hdr=%h exp link=%0d",
                             cyc, bus.out_valid, bus.out_link, bus.out_header, lnk);
        end
      end
      tick();
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_single();
    apply_reset();
    set_link(2, 96'hA5, 32'hDEAD, 3'd2, 1'b1);
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant got=%b exp=0100", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_is_pld !== 1'b0 || bus.out_link !== 3'd2 ||
        bus.out_header !== 96'hA5 || bus.out_dest !== 3'd2 || bus.out_payload !== 32'h0) begin
      n_fail++; $display("FAIL single_hdr valid=%b pld=%b link=%0d hdr=%h dest=%0d pay=%h",
                         bus.out_valid, bus.out_is_pld, bus.out_link, bus.out_header,
                         bus.out_dest, bus.out_payload);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_is_pld !== 1'b1 || bus.out_payload !== 32'hDEAD ||
        bus.out_header !== 96'hA5 || bus.out_link !== 3'd2) begin
      n_fail++; $display("FAIL single_pld valid=%b pld=%b pay=%h hdr=%h link=%0d exp pay=dead",
                         bus.out_valid, bus.out_is_pld, bus.out_payload, bus.out_header,
                         bus.out_link);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle valid=%b busy=%b exp=0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_link(0, 96'h1234_5678_9ABC_DEF0_1111_2222, 32'h0, 3'd3, 1'b0);
    set_link(1, 96'h77, 32'h0, 3'd3, 1'b0);
    bus.req_valid = 4'b0011;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_grant got=%b exp=0001", bus.req_ready);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_header !== 96'h1234_5678_9ABC_DEF0_1111_2222 ||
          bus.req_ready !== 4'b0000 || bus.out_dest !== 3'd3) begin
        n_fail++; $display("FAIL bp_hold k=%0d valid=%b hdr=%h rdy=%b dest=%0d", k,
                           bus.out_valid, bus.out_header, bus.req_ready, bus.out_dest);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL bp_gap valid=%b rdy=%b exp=0 0000", bus.out_valid, bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_next_grant got=%b exp=0010", bus.req_ready);
    end
    bus.req_valid = 4'b0000;
  endtask

  // Link 0 continuously valid with payload; link 2 joins and must get the next slot.
  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    apply_reset();
    set_link(0, 96'h10, 32'hA0, 3'd2, 1'b1);
    set_link(2, 96'h12, 32'hA2, 3'd3, 1'b1);
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      exp_rdy = (cyc == 0 || cyc == 8) ? 4'b0001 : (cyc == 4) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (bus.req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
      end
      if (cyc == 2 || cyc == 6) begin
        n_checks++;
        if (bus.out_is_pld !== 1'b1 || bus.out_payload !== ((cyc == 2) ? 32'hA0 : 32'hA2)) begin
          n_fail++; $display("FAIL b2b_pld cyc=%0d pld=%b pay=%h", cyc, bus.out_is_pld,
                             bus.out_payload);
        end
      end
      if (cyc == 1) bus.req_valid = 4'b0101;
      tick();
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_invalid_dest();
    logic seen_valid;
    apply_reset();
    for (int i = 0; i < 4; i++) set_link(i, 96'h0, 32'h0, 3'd0, 1'b0);
    set_link(1, 96'hBAD, 32'h0, 3'd0, 1'b1);
    bus.req_valid = 4'b0010;
    bus.out_ready = 1'b1;
    seen_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL drop_grant got=%b exp=0010", bus.req_ready);
    end
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
      if (k == 10 || k == 254 || k == 255 || k == 300) begin
        n_checks++;
        if (drop_count !== ((k >= 255) ? 8'd255 : 8'(k))) begin
          n_fail++; $display("FAIL drop_count k=%0d got=%0d", k, drop_count);
        end
      end
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_no_beat out_valid seen=%b exp=0", seen_valid);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_reset_in_pld();
    apply_reset();
    set_link(1, 96'hBEEF, 32'h1234, 3'd2, 1'b1);
    bus.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rstpld_grant got=%b exp=0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_is_pld !== 1'b1 || bus.out_payload !== 32'h1234) begin
      n_fail++; $display("FAIL rstpld_in_pld pld=%b pay=%h exp=1 1234", bus.out_is_pld,
                         bus.out_payload);
    end
    rst_n = 1'b0;
    set_link(1, 96'hCAFE, 32'h0, 3'd1, 1'b0);
    set_link(3, 96'hF00D, 32'h0, 3'd1, 1'b0);
    bus.req_valid = 4'b1010;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstpld_during valid=%b rdy=%b busy=%b", bus.out_valid,
                         bus.req_ready, busy);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rstpld_after valid=%b rdy=%b exp=0 0010", bus.out_valid,
                         bus.req_ready);
    end
    tick();
    n_checks++;
    if (bus.out_header !== 96'hCAFE || bus.out_is_pld !== 1'b0 || bus.out_link !== 3'd1) begin
      n_fail++; $display("FAIL rstpld_new_beat hdr=%h pld=%b link=%0d exp=cafe 0 1",
                         bus.out_header, bus.out_is_pld, bus.out_link);
    end
    bus.req_valid = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_header = '0;
    bus.req_payload = '0;
    bus.req_dest = '0;
    bus.req_has_pld = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_rr_order();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_invalid_dest();
    test_reset_in_pld();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
